mips_hazard_ctrl: RTL and testbench

- Pipeline sequencing unit for the 5-stage MIPS32 core. It generates the per-stage write-enable and synchronous-flush strobes that the pipelined control decoder and the datapath registers consume.
- It detects load-use hazards, branch, jump and eret redirects, exceptions and data-memory wait states, and drives the exec-stage forwarding selects.
- It is the producer end of the stage enable/flush interface (we_*, s_rst_*).

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_hazard_ctrl_if.sv | 45 ++++
 rtl/mips_fwd_unit.sv | 21 ++
 rtl/mips_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 pipeline sequencing logic.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_EXC
    } hz_state_t;

    localparam logic [2:0] PC_SEL_SEQ = 3'd0;
    localparam logic [2:0] PC_SEL_BR  = 3'd1;
    localparam logic [2:0] PC_SEL_JMP = 3'd2;
    localparam logic [2:0] PC_SEL_EXC = 3'd3;
    localparam logic [2:0] PC_SEL_EPC = 3'd4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Hazard-unit bundle: pipeline status in, stage enables/flushes/selects out.
interface mips_hazard_ctrl_if #(parameter int CNT_W = 32);

    logic [4:0]       i_rs_dec, i_rt_dec;
    logic             i_use_rs_dec, i_use_rt_dec;
    logic             i_jump_dec, i_eret_dec;
    logic [4:0]       i_rs_exec, i_rt_exec;
    logic             i_lw_exec, i_regwrite_exec;
    logic [4:0]       i_wreg_exec;
    logic             i_regwrite_memac;
    logic [4:0]       i_wreg_memac;
    logic             i_regwrite_wrbc;
    logic [4:0]       i_wreg_wrbc;
    logic             i_branch_taken, i_exc_req;
    logic             i_dmem_req, i_dmem_ready;

    logic             o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc;
    logic             o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc;
    logic [2:0]       o_pc_sel;
    logic             o_epc_we;
    logic [1:0]       o_fwd_a, o_fwd_b;
    logic             o_bus_err;
    logic [CNT_W-1:0] o_stall_cycles;

    modport master (
        input  i_rs_dec, i_rt_dec, i_use_rs_dec, i_use_rt_dec, i_jump_dec, i_eret_dec,
               i_rs_exec, i_rt_exec, i_lw_exec, i_regwrite_exec, i_wreg_exec,
               i_regwrite_memac, i_wreg_memac, i_regwrite_wrbc, i_wreg_wrbc,
               i_branch_taken, i_exc_req, i_dmem_req, i_dmem_ready,
        output o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc,
               o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc,
               o_pc_sel, o_epc_we, o_fwd_a, o_fwd_b, o_bus_err, o_stall_cycles
    );

    modport slave (
        output i_rs_dec, i_rt_dec, i_use_rs_dec, i_use_rt_dec, i_jump_dec, i_eret_dec,
               i_rs_exec, i_rt_exec, i_lw_exec, i_regwrite_exec, i_wreg_exec,
               i_regwrite_memac, i_wreg_memac, i_regwrite_wrbc, i_wreg_wrbc,
               i_branch_taken, i_exc_req, i_dmem_req, i_dmem_ready,
        input  o_we_pc, o_we_dec, o_we_exec, o_we_MemAc, o_we_WrBc,
               o_s_rst_dec, o_s_rst_exec, o_s_rst_MemAc, o_s_rst_WrBc,
               o_pc_sel, o_epc_we, o_fwd_a, o_fwd_b, o_bus_err, o_stall_cycles
    );

endinterface

// File: rtl/mips_fwd_unit.sv
// Exec-operand forwarding select for one source register; MemAc is the newer value.
module mips_fwd_unit
    import mips_pkg::*;
(
    input  logic [4:0] src,
    input  logic       regwrite_memac,
    input  logic [4:0] wreg_memac,
    input  logic       regwrite_wrbc,
    input  logic [4:0] wreg_wrbc,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regwrite_memac && wreg_memac != REG_ZERO && wreg_memac == src)
            fwd = FWD_MEM;
        else if (regwrite_wrbc && wreg_wrbc != REG_ZERO && wreg_wrbc == src)
            fwd = FWD_WB;
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, PC select, memory-wait freeze with
// timeout, exception redirect, and exec-stage forwarding selects.
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_a_rst_n,
    mips_hazard_ctrl_if.master hz
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use, mem_stall;
    logic              do_exc, do_freeze, do_run, bus_err;
    logic [1:0]        fwd_a, fwd_b;

    assign load_use = hz.i_lw_exec && hz.i_regwrite_exec && hz.i_wreg_exec != REG_ZERO &&
                      ((hz.i_use_rs_dec && hz.i_rs_dec == hz.i_wreg_exec) ||
                       (hz.i_use_rt_dec && hz.i_rt_dec == hz.i_wreg_exec));
    assign mem_stall = hz.i_dmem_req && !hz.i_dmem_ready;

    // Decide which action class applies this cycle and where the FSM goes next.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        do_exc    = 1'b0;
        do_freeze = 1'b0;
        do_run    = 1'b0;
        bus_err   = 1'b0;
        case (state)
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (hz.i_exc_req) begin
                    do_exc = 1'b1;
                end else if (mem_stall) begin
                    do_freeze = 1'b1;
                    wait_nxt  = WAIT_W'(1);
                    state_nxt = ST_MEM_WAIT;
                end else begin
                    do_run = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.i_exc_req) begin
                    do_exc = 1'b1;
                end else if (hz.i_dmem_ready) begin
                    do_run    = 1'b1;
                    state_nxt = ST_RUN;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // The RUN cycle that entered the wait counts as wait cycle 1.
                    do_exc  = 1'b1;
                    bus_err = 1'b1;
                end else begin
                    do_freeze = 1'b1;
                    wait_nxt  = wait_cnt + WAIT_W'(1);
                end
            end
            ST_EXC:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
        if (do_exc) state_nxt = ST_EXC;
    end

    always_comb begin
        hz.o_we_pc       = 1'b1;
        hz.o_we_dec      = 1'b1;
        hz.o_we_exec     = 1'b1;
        hz.o_we_MemAc    = 1'b1;
        hz.o_we_WrBc     = 1'b1;
        hz.o_s_rst_dec   = 1'b0;
        hz.o_s_rst_exec  = 1'b0;
        hz.o_s_rst_MemAc = 1'b0;
        hz.o_s_rst_WrBc  = 1'b0;
        hz.o_pc_sel      = PC_SEL_SEQ;
        hz.o_epc_we      = 1'b0;
        if (state == ST_INIT) begin
            hz.o_we_pc       = 1'b0;
            hz.o_we_dec      = 1'b0;
            hz.o_we_exec     = 1'b0;
            hz.o_we_MemAc    = 1'b0;
            hz.o_we_WrBc     = 1'b0;
            hz.o_s_rst_dec   = 1'b1;
            hz.o_s_rst_exec  = 1'b1;
            hz.o_s_rst_MemAc = 1'b1;
            hz.o_s_rst_WrBc  = 1'b1;
        end else if (state == ST_EXC) begin
            hz.o_s_rst_dec = 1'b1;
        end else if (do_exc) begin
            hz.o_epc_we      = 1'b1;
            hz.o_pc_sel      = PC_SEL_EXC;
            hz.o_s_rst_dec   = 1'b1;
            hz.o_s_rst_exec  = 1'b1;
            hz.o_s_rst_MemAc = 1'b1;
        end else if (do_freeze) begin
            // WrBc is flushed so the held MemAc instruction is not written back twice.
            hz.o_we_pc      = 1'b0;
            hz.o_we_dec     = 1'b0;
            hz.o_we_exec    = 1'b0;
            hz.o_we_MemAc   = 1'b0;
            hz.o_s_rst_WrBc = 1'b1;
        end else if (do_run) begin
            if (hz.i_branch_taken) begin
                hz.o_pc_sel     = PC_SEL_BR;
                hz.o_s_rst_dec  = 1'b1;
                hz.o_s_rst_exec = 1'b1;
            end else if (load_use) begin
                hz.o_we_pc      = 1'b0;
                hz.o_we_dec     = 1'b0;
                hz.o_s_rst_exec = 1'b1;
            end else if (hz.i_eret_dec) begin
                hz.o_pc_sel    = PC_SEL_EPC;
                hz.o_s_rst_dec = 1'b1;
            end else if (hz.i_jump_dec) begin
                hz.o_pc_sel    = PC_SEL_JMP;
                hz.o_s_rst_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state     <= ST_INIT;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!hz.o_we_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    mips_fwd_unit u_fwd_a (
        .src            (hz.i_rs_exec),
        .regwrite_memac (hz.i_regwrite_memac),
        .wreg_memac     (hz.i_wreg_memac),
        .regwrite_wrbc  (hz.i_regwrite_wrbc),
        .wreg_wrbc      (hz.i_wreg_wrbc),
        .fwd            (fwd_a)
    );

    mips_fwd_unit u_fwd_b (
        .src            (hz.i_rt_exec),
        .regwrite_memac (hz.i_regwrite_memac),
        .wreg_memac     (hz.i_wreg_memac),
        .regwrite_wrbc  (hz.i_regwrite_wrbc),
        .wreg_wrbc      (hz.i_wreg_wrbc),
        .fwd            (fwd_b)
    );

    assign hz.o_fwd_a        = i_a_rst_n ? fwd_a : FWD_RF;
    assign hz.o_fwd_b        = i_a_rst_n ? fwd_b : FWD_RF;
    assign hz.o_bus_err      = bus_err;
    assign hz.o_stall_cycles = stall_cnt;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl with hand-computed expected outputs.
module tb_mips_hazard_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_hazard_ctrl_if #(.CNT_W(32)) bus ();

    mips_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .i_clk     (clk),
        .i_a_rst_n (rst_n),
        .hz        (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        bus.i_rs_dec = 0; bus.i_rt_dec = 0; bus.i_use_rs_dec = 0; bus.i_use_rt_dec = 0;
        bus.i_jump_dec = 0; bus.i_eret_dec = 0; bus.i_rs_exec = 0; bus.i_rt_exec = 0;
        bus.i_lw_exec = 0; bus.i_regwrite_exec = 0; bus.i_wreg_exec = 0;
        bus.i_regwrite_memac = 0; bus.i_wreg_memac = 0; bus.i_regwrite_wrbc = 0; bus.i_wreg_wrbc = 0;
        bus.i_branch_taken = 0; bus.i_exc_req = 0; bus.i_dmem_req = 0; bus.i_dmem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use8();
        bus.i_lw_exec = 1; bus.i_regwrite_exec = 1; bus.i_wreg_exec = 8;
        bus.i_rs_dec = 8; bus.i_use_rs_dec = 1;
    endtask

    // we = {pc,dec,exec,MemAc,WrBc}, srst = {dec,exec,MemAc,WrBc}
    task automatic cyc(input string tag, input logic [4:0] we, input logic [3:0] srst,
                       input logic [2:0] pcs, input logic epc, input logic berr);
        #2;
        chk({tag, ".we"}, 32'({bus.o_we_pc, bus.o_we_dec, bus.o_we_exec, bus.o_we_MemAc, bus.o_we_WrBc}), 32'(we));
        chk({tag, ".srst"}, 32'({bus.o_s_rst_dec, bus.o_s_rst_exec, bus.o_s_rst_MemAc, bus.o_s_rst_WrBc}), 32'(srst));
        chk({tag, ".pc_sel"}, 32'(bus.o_pc_sel), 32'(pcs));
        chk({tag, ".epc_we"}, 32'(bus.o_epc_we), 32'(epc));
        chk({tag, ".bus_err"}, 32'(bus.o_bus_err), 32'(berr));
        chk({tag, ".stall"}, bus.o_stall_cycles, 32'(exp_stall));
        if (!we[4]) exp_stall++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.i_regwrite_memac = 1; bus.i_wreg_memac = 5; bus.i_rs_exec = 5;
        #3;
        chk("rst.we", 32'({bus.o_we_pc, bus.o_we_dec, bus.o_we_exec, bus.o_we_MemAc, bus.o_we_WrBc}), 32'h0);
        chk("rst.srst", 32'({bus.o_s_rst_dec, bus.o_s_rst_exec, bus.o_s_rst_MemAc, bus.o_s_rst_WrBc}), 32'hF);
        chk("rst.pc_sel", 32'(bus.o_pc_sel), 32'd0);
        chk("rst.fwd_a", 32'(bus.o_fwd_a), 32'd0);
        chk("rst.stall", bus.o_stall_cycles, 32'd0);
        idle();
        #9 rst_n = 1'b1;
        cyc("init", 5'b00000, 4'b1111, 3'd0, 0, 0);
        tick(); cyc("run_idle", 5'b11111, 4'b0000, 3'd0, 0, 0);

        tick(); load_use8();
        cyc("ld_use_rs", 5'b00111, 4'b0100, 3'd0, 0, 0);
        tick(); idle(); cyc("ld_use_done", 5'b11111, 4'b0000, 3'd0, 0, 0);
        tick(); bus.i_lw_exec = 1; bus.i_regwrite_exec = 1; bus.i_use_rs_dec = 1;
        cyc("ld_use_r0", 5'b11111, 4'b0000, 3'd0, 0, 0);
        tick(); bus.i_wreg_exec = 9; bus.i_rt_dec = 9; bus.i_use_rt_dec = 1; bus.i_use_rs_dec = 0;
        cyc("ld_use_rt", 5'b00111, 4'b0100, 3'd0, 0, 0);
        tick(); bus.i_use_rt_dec = 0; cyc("ld_no_use", 5'b11111, 4'b0000, 3'd0, 0, 0);
        tick(); bus.i_use_rt_dec = 1; bus.i_regwrite_exec = 0;
        cyc("ld_no_rgw", 5'b11111, 4'b0000, 3'd0, 0, 0);

        tick(); idle(); load_use8(); bus.i_branch_taken = 1; bus.i_jump_dec = 1;
        cyc("br_over_jmp", 5'b11111, 4'b1100, PC_SEL_BR, 0, 0);
        tick(); idle(); bus.i_eret_dec = 1; bus.i_jump_dec = 1;
        cyc("eret", 5'b11111, 4'b1000, PC_SEL_EPC, 0, 0);
        tick(); idle(); bus.i_jump_dec = 1; cyc("jump", 5'b11111, 4'b1000, PC_SEL_JMP, 0, 0);
        tick(); load_use8(); cyc("ld_use_jmp", 5'b00111, 4'b0100, 3'd0, 0, 0);
        tick(); idle(); bus.i_jump_dec = 1; cyc("jump_retry", 5'b11111, 4'b1000, PC_SEL_JMP, 0, 0);

        tick(); idle(); bus.i_dmem_req = 1;
        cyc("mw_c1", 5'b00001, 4'b0001, 3'd0, 0, 0);
        tick(); cyc("mw_c2", 5'b00001, 4'b0001, 3'd0, 0, 0);
        tick(); cyc("mw_c3", 5'b00001, 4'b0001, 3'd0, 0, 0);
        tick(); bus.i_dmem_ready = 1; cyc("mw_rdy", 5'b11111, 4'b0000, 3'd0, 0, 0);
        tick(); idle(); cyc("mw_after", 5'b11111, 4'b0000, 3'd0, 0, 0);

        tick(); bus.i_dmem_req = 1;
        cyc("to_c1", 5'b00001, 4'b0001, 3'd0, 0, 0);
        for (int i = 2; i <= 15; i++) begin
            tick(); cyc($sformatf("to_c%0d", i), 5'b00001, 4'b0001, 3'd0, 0, 0);
        end
        tick(); cyc("to_c16", 5'b11111, 4'b1110, PC_SEL_EXC, 1, 1);
        tick(); idle(); cyc("to_exc", 5'b11111, 4'b1000, 3'd0, 0, 0);
        tick(); cyc("to_run", 5'b11111, 4'b0000, 3'd0, 0, 0);

        tick(); bus.i_regwrite_memac = 1; bus.i_wreg_memac = 5; bus.i_regwrite_wrbc = 1;
        bus.i_wreg_wrbc = 5; bus.i_rs_exec = 5; bus.i_rt_exec = 5;
        #2;
        chk("fwd_a_mem", 32'(bus.o_fwd_a), 32'(FWD_MEM));
        chk("fwd_b_mem", 32'(bus.o_fwd_b), 32'(FWD_MEM));
        bus.i_regwrite_memac = 0;
        #1;
        chk("fwd_a_wb", 32'(bus.o_fwd_a), 32'(FWD_WB));
        bus.i_regwrite_memac = 1; bus.i_wreg_memac = 0; bus.i_wreg_wrbc = 0; bus.i_rs_exec = 0;
        bus.i_rt_exec = 6; bus.i_wreg_wrbc = 6;
        #1;
        chk("fwd_a_r0", 32'(bus.o_fwd_a), 32'(FWD_RF));
        chk("fwd_b_wb", 32'(bus.o_fwd_b), 32'(FWD_WB));

        tick(); idle(); load_use8(); bus.i_exc_req = 1;
        cyc("exc_ld", 5'b11111, 4'b1110, PC_SEL_EXC, 1, 0);
        tick(); idle(); cyc("exc_rec", 5'b11111, 4'b1000, 3'd0, 0, 0);
        tick(); cyc("exc_run", 5'b11111, 4'b0000, 3'd0, 0, 0);

        tick(); bus.i_dmem_req = 1; cyc("mwx_c1", 5'b00001, 4'b0001, 3'd0, 0, 0);
        tick(); bus.i_exc_req = 1; cyc("mwx_exc", 5'b11111, 4'b1110, PC_SEL_EXC, 1, 0);
        tick(); idle(); cyc("mwx_rec", 5'b11111, 4'b1000, 3'd0, 0, 0);

        tick(); bus.i_dmem_req = 1; cyc("ar_c1", 5'b00001, 4'b0001, 3'd0, 0, 0);
        tick(); cyc("ar_c2", 5'b00001, 4'b0001, 3'd0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar.we", 32'({bus.o_we_pc, bus.o_we_dec, bus.o_we_exec, bus.o_we_MemAc, bus.o_we_WrBc}), 32'h0);
        chk("ar.srst", 32'({bus.o_s_rst_dec, bus.o_s_rst_exec, bus.o_s_rst_MemAc, bus.o_s_rst_WrBc}), 32'hF);
        chk("ar.stall", bus.o_stall_cycles, 32'd0);
        exp_stall = 0;
        idle();
        #1 rst_n = 1'b1;
        cyc("ar_init", 5'b00000, 4'b1111, 3'd0, 0, 0);
        tick(); cyc("ar_run", 5'b11111, 4'b0000, 3'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
